// File: rtl/nios_onchip_reader.sv
// Avalon-MM burst-free reader: drains a contiguous word block from on-chip RAM onto a valid/ready stream.
// Optional running checksum of streamed words is enabled by defining NIOS_ONCHIP_READER_CHECKSUM_EN.
module nios_onchip_reader #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [ADDR_W:0]       cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_last,
  output logic [DATA_W-1:0]     checksum
);
  localparam int LEN_W = ADDR_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    deliv_q, deliv_d;
  logic [CNT_W-1:0]    outst_q, fcnt_q;
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [READ_LATENCY-1:0] lat_q;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic                start_ok, rd_req, rd_acc, ret_vld, beat, last_beat;
  logic [CRD_W-1:0]    credit_used;

  assign start_ok    = (state_q == IDLE) && cmd_start;
  // Credits cover both buffered words and reads still in the RAM pipeline, so the FIFO cannot overflow.
  assign credit_used = {1'b0, fcnt_q} + {1'b0, outst_q};
  assign rd_req      = (state_q == READ) && (issued_q < len_q) && (credit_used < CRD_W'(FIFO_DEPTH));
  assign rd_acc      = rd_req && !avm_waitrequest;
  assign ret_vld     = lat_q[READ_LATENCY-1];
  assign beat        = st_valid && st_ready;
  assign last_beat   = (deliv_q == len_q - LEN_W'(1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    deliv_d  = deliv_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          issued_d = '0;
          deliv_d  = '0;
          if (cmd_len == '0) done_d = 1'b1;
          else               state_d = READ;
        end
      end
      READ: begin
        if (rd_acc) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + LEN_W'(1);
          if (issued_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (beat) deliv_d = deliv_q + LEN_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      deliv_q  <= '0;
      done_q   <= 1'b0;
      outst_q  <= '0;
      fcnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      deliv_q  <= deliv_d;
      done_q   <= done_d;
      outst_q  <= outst_q + CNT_W'(rd_acc) - CNT_W'(ret_vld);
      fcnt_q   <= fcnt_q + CNT_W'(ret_vld) - CNT_W'(beat);
      if (ret_vld) wptr_q <= wptr_q + PTR_W'(1);
      if (beat)    rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) lat_q <= '0;
        else       lat_q <= rd_acc;
      end
    end else begin : g_latn
      always_ff @(posedge clk or posedge reset) begin
        if (reset) lat_q <= '0;
        else       lat_q <= {lat_q[READ_LATENCY-2:0], rd_acc};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (ret_vld) fifo_mem[wptr_q] <= avm_readdata;
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_req;
  assign avm_chipselect = rd_req;
  assign avm_byteenable = '1;
  assign st_valid       = (fcnt_q != '0);
  // Data is masked when empty so the stream output reads zero after reset.
  assign st_data        = st_valid ? fifo_mem[rptr_q] : '0;
  assign st_last        = st_valid && last_beat;

`ifdef NIOS_ONCHIP_READER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_ok)  sum_d = '0;
    else if (beat) sum_d = sum_q + st_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_nios_onchip_reader.sv
// Directed bench for nios_onchip_reader with a latency-1 RAM model and per-beat scoreboard.
module tb_nios_onchip_reader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_start = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          busy, done;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_read;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0] avm_readdata;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] st_data;
  logic          st_valid;
  logic          st_ready = 1'b1;
  logic          st_last;
  logic [DW-1:0] checksum;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rdata_q = '0;
  int errors = 0;
  int checks = 0;

  nios_onchip_reader dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_last(st_last), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // On-chip RAM model: data appears one cycle after the accepted read.
  always @(posedge clk) if (avm_read && !avm_waitrequest) rdata_q <= mem[avm_address];
  assign avm_readdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_read"}, avm_read, 0);
    chk({tag, "_cs"}, avm_chipselect, 0);
    chk({tag, "_addr"}, avm_address, 0);
    chk({tag, "_be"}, avm_byteenable, 4'hF);
    chk({tag, "_valid"}, st_valid, 0);
    chk({tag, "_data"}, st_data, 0);
    chk({tag, "_last"}, st_last, 0);
    chk({tag, "_csum"}, checksum, 0);
  endtask

  // rmode 0: ready always high; 1: ready toggles. strict checks no-stall timing.
  task automatic run_xfer(input int a, input int n, input int rmode, input bit wrand,
                          input int abort, input int ign, input bit strict,
                          output logic [31:0] sum_o);
    int cyc, nbeats, nreads, first_b, last_b, done_cyc, max_infl;
    logic [31:0] sum, p_data;
    logic pst_stall, pav_stall, p_last, timed_out;
    logic [AW-1:0] p_addr;
    cyc = 0; nbeats = 0; nreads = 0; first_b = -1; last_b = -1; done_cyc = -1; max_infl = 0;
    sum = '0; p_data = '0; pst_stall = 0; pav_stall = 0; p_last = 0; p_addr = '0; timed_out = 0;
    cmd_addr = AW'(a); cmd_len = (AW+1)'(n); cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0; cyc = 1;
    chk("busy_c1", busy, 32'(n != 0));
    chk("read_c1", avm_read, 32'(n != 0));
    if (n != 0) chk("addr_c1", avm_address, 32'(a));
    forever begin
      st_ready = (rmode == 0) ? 1'b1 : 1'((cyc % 2) == 1);
      avm_waitrequest = wrand ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cyc == ign) begin
        cmd_start = 1'b1; cmd_addr = AW'(700); cmd_len = (AW+1)'(3);
      end else cmd_start = 1'b0;
      #1;
      if (pav_stall) begin
        chk("hold_read", avm_read, 1);
        chk("hold_addr", avm_address, p_addr);
      end
      if (pst_stall) begin
        chk("hold_valid", st_valid, 1);
        chk("hold_data", st_data, p_data);
        chk("hold_last", st_last, p_last);
      end
      if (avm_read && !avm_waitrequest) begin
        chk("rd_addr", avm_address, 32'((a + nreads) % 1024));
        nreads++;
      end
      if (nreads - nbeats > max_infl) max_infl = nreads - nbeats;
      if (done) begin
        done_cyc = cyc;
        chk("valid_at_done", st_valid, 0);
        break;
      end
      if (st_valid && st_ready) begin
        chk("data", st_data, mem[(a + nbeats) % 1024]);
        chk("last", st_last, 32'(nbeats == n - 1));
        sum = sum + mem[(a + nbeats) % 1024];
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
        nbeats++;
      end
      pst_stall = st_valid && !st_ready; p_data = st_data; p_last = st_last;
      pav_stall = avm_read && avm_waitrequest; p_addr = avm_address;
      if (cyc >= 400) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort > 0 && nbeats >= abort) begin
        sum_o = sum;
        return;
      end
    end
    cmd_start = 1'b0;
    sum_o = sum;
    chk("timeout", 32'(timed_out), 0);
    chk("nbeats", nbeats, n);
    chk("nreads", nreads, n);
    chk("busy_at_done", busy, 0);
    chk("done_cycle", done_cyc, (n == 0) ? 1 : last_b + 1);
    chk("credit_le4", 32'(max_infl <= 4), 1);
`ifdef NIOS_ONCHIP_READER_CHECKSUM_EN
    chk("csum_done", checksum, sum);
`else
    chk("csum_done", checksum, 0);
`endif
    if (strict) begin
      chk("first_lat", first_b, 3);
      chk("consecutive", last_b - first_b, n - 1);
    end
  endtask

  initial begin
    logic [31:0] s;
    logic saw;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    run_xfer(5, 8, 0, 0, 0, 4, 1, s);
    run_xfer(1020, 6, 0, 0, 0, 0, 1, s);

    run_xfer(0, 0, 0, 0, 0, 0, 0, s);
    saw = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk("len0_done_once", done, 0);
      if (avm_read || st_valid) saw = 1;
    end
    chk("len0_quiet", saw, 0);

    run_xfer(100, 16, 1, 1, 0, 0, 0, s);
    st_ready = 1'b1; avm_waitrequest = 1'b0;

    run_xfer(40, 16, 0, 0, 3, 0, 0, s);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_xfer(0, 2, 0, 0, 0, 0, 1, s);

    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'hFFFF_FFFF;
    run_xfer(0, 4, 0, 0, 0, 0, 1, s);
    @(posedge clk); #1;
`ifdef NIOS_ONCHIP_READER_CHECKSUM_EN
    chk("csum_hold", checksum, 32'h5);
`else
    chk("csum_hold", checksum, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nios_onchip_reader.md
# nios_onchip_reader

Avalon-MM master that streams a contiguous block of 32-bit words out of the Nios on-chip memory slave (fixed read latency, single port) onto a valid/ready stream. Sits between the on-chip memory's spare slave port and the camera output path, so frame-line buffers can be drained without CPU load loops. It is configured per transfer by a start pulse carrying word address and length. It signals completion with a one-cycle pulse.

## Interface
- ADDR_W, 10, word-address width of the slave (1024 words)
- DATA_W, 32, data width
- READ_LATENCY, 1, cycles from read acceptance to valid avm_readdata (1 = unregistered RAM output)
- FIFO_DEPTH, 4, output buffer entries; power of two, >= READ_LATENCY+2

- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  start pulse; sampled only in IDLE
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  word count, 0..2^ADDR_W
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse, transfer complete
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  equals avm_read
- avm_read  out  1  read request
- avm_byteenable  out  DATA_W/8  constant all-ones
- avm_readdata  in  DATA_W  read data
- avm_waitrequest  in  1  slave stall; tie 0 for the on-chip RAM
- st_data  out  DATA_W  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  stream ready
- st_last  out  1  marks final word of transfer
- checksum  out  DATA_W  see Configuration

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: on cmd_start, latch addr/len, clear counters. If len=0, pulse done next cycle and stay IDLE. Otherwise go to READ.
- READ: assert avm_read when issued < len and (fifo_count + outstanding) < FIFO_DEPTH. A read is accepted when avm_read & !avm_waitrequest; then address increments modulo 2^ADDR_W (1023 wraps to 0). avm_address/avm_read hold stable while waitrequest is high. Go to DRAIN when the last read is accepted.
- Return path: a READ_LATENCY-deep shift register of accept flags. When a flag emerges, avm_readdata is written into the FIFO. The credit rule guarantees the FIFO never overflows.
- Stream: st_valid = FIFO non-empty. A beat transfers on st_valid & st_ready. st_data/st_valid/st_last hold stable while st_ready is low. st_last is high on the beat whose delivered count = len-1.
- DRAIN: when the last beat transfers, pulse done for one cycle, drop busy, and return to IDLE.
- cmd_start while busy is ignored, with no side effects.
- Reset (async, any state): state IDLE, FIFO and counters flushed. Any in-flight read data is discarded. All outputs are 0 except avm_byteenable, which is all-ones.

## Timing
- Start accepted at edge 0: busy=1 and avm_read=1 with avm_address=cmd_addr in cycle 1.
- Read accepted at edge N: data captured at edge N+READ_LATENCY. st_valid is high in the following cycle.
- First-word latency with no stall: READ_LATENCY+2 cycles from the start edge.
- Throughput: one word/cycle sustained with st_ready=1 and waitrequest=0.
- done is asserted in the cycle after the last beat transfers. The block accepts a new cmd_start in that same cycle.

## Configuration
- NIOS_ONCHIP_READER_CHECKSUM_EN defined: checksum is a running modulo-2^DATA_W sum of all transferred st_data words. It is cleared on accepted start and is valid and stable from the done pulse until the next start.
- Undefined: the checksum logic is absent and the checksum output is constant 0.

## Test plan
- mem[i]=i+0x100, start addr=5 len=8, st_ready=1 -> st_data 0x105..0x10C on 8 consecutive cycles, st_last on 0x10C, done one cycle later, busy low after.
- addr=1020 len=6 -> reads at 1020,1021,1022,1023,0,1 in order; data matches mem.
- len=0 -> done one cycle after start, no avm_read asserted, st_valid stays 0.
- len=16, st_ready toggling 1-0 each cycle plus random waitrequest -> no data lost or duplicated, outstanding+fifo never exceeds 4, and held signals are stable while stalled.
- Reset asserted mid-transfer after 3 beats -> all outputs 0 immediately. The next start addr=0 len=2 yields exactly mem[0], mem[1].
- With NIOS_ONCHIP_READER_CHECKSUM_EN, mem[0..3]=1,2,3,0xFFFFFFFF, len=4 -> checksum=0x00000005 at done. Without the macro, checksum=0.
